// File: rtl/ifu_fetch_queue.sv
// Fetch-side producer for the F/D register: issues word fetches against a credit
// budget, tags them with their PC, and queues returned words in order.
module ifu_fetch_queue #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_en
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 2;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  logic [31:0]   r_fpc;
  cnt_t          r_occ;
  cnt_t          r_inflight;
  cnt_t          r_drop;
  logic [AW-1:0] r_q_wr;
  logic [AW-1:0] r_q_rd;
  logic [AW-1:0] r_t_wr;
  logic [AW-1:0] r_t_rd;
  logic [31:0]   r_q_pc    [DEPTH];
  logic [31:0]   r_q_instr [DEPTH];
  logic [31:0]   r_tag     [DEPTH];

  logic w_credit;
  logic w_grant;
  logic w_rsp;
  logic w_keep;
  logic w_discard;
  logic w_pop;
  logic w_unused_lsb;

  // Credits count queued words plus outstanding requests so the queue cannot overflow.
  assign w_credit  = (r_occ + r_inflight) < DEPTH_C;
  assign im_req    = ~reset & ~redirect & w_credit;
  assign im_addr   = r_fpc;
  assign w_grant   = im_req & im_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp     = im_rvalid & (r_inflight != '0);
  assign w_discard = w_rsp & (r_drop != '0);
  assign w_keep    = w_rsp & (r_drop == '0) & ~redirect;
  assign w_pop     = f_valid & ~stall & ~redirect;

  assign f_valid   = (r_occ != '0);
  assign f_pc      = f_valid ? r_q_pc[r_q_rd] : PC_RESET;
  assign f_instr   = f_valid ? r_q_instr[r_q_rd] : 32'h0;
  assign f_en      = ~stall;
  assign w_unused_lsb = ^redirect_pc[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fpc      <= PC_RESET;
      r_occ      <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
      r_q_wr     <= '0;
      r_q_rd     <= '0;
      r_t_wr     <= '0;
      r_t_rd     <= '0;
    end else if (redirect) begin
      // Everything still outstanding belongs to the old path and must be discarded.
      r_fpc      <= word_align(redirect_pc);
      r_occ      <= '0;
      r_q_wr     <= '0;
      r_q_rd     <= '0;
      r_t_wr     <= '0;
      r_t_rd     <= '0;
      r_inflight <= r_inflight - cnt_t'(w_rsp);
      r_drop     <= r_inflight - cnt_t'(w_rsp);
    end else begin
      if (w_grant) begin
        r_fpc  <= r_fpc + 32'd4;
        r_t_wr <= r_t_wr + 1'b1;
      end
      if (w_keep) begin
        r_q_wr <= r_q_wr + 1'b1;
        r_t_rd <= r_t_rd + 1'b1;
      end
      if (w_pop) begin
        r_q_rd <= r_q_rd + 1'b1;
      end
      r_inflight <= r_inflight + cnt_t'(w_grant) - cnt_t'(w_rsp);
      r_drop     <= r_drop - cnt_t'(w_discard);
      r_occ      <= r_occ + cnt_t'(w_keep) - cnt_t'(w_pop);
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_tag[r_t_wr] <= r_fpc;
    end
    if (w_keep) begin
      r_q_pc[r_q_wr]    <= r_tag[r_t_rd];
      r_q_instr[r_q_wr] <= im_rdata;
    end
  end

endmodule

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
- Fetch-side producer for the F/D pipeline register: generates fetch PCs, issues pipelined requests to instruction memory, and buffers returned words with their PCs in an in-order queue.
- Presents {PC, instr} to the F/D register every cycle and honours D-stage stall and branch/jump redirect from the decode/execute side.
- Decouples variable-latency instruction memory from the pipeline.

Parameters:
- PC_RESET, 32'h0000_3000, fetch PC after reset; also the f_pc value when the queue is empty.
- DEPTH, 4, queue entries and max outstanding requests; power of 2, >=2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  F/D register holding; the head entry is not consumed.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] forced to 0.
- im_req  out  1  request valid.
- im_addr  out  32  request address (word aligned).
- im_gnt  in  1  request accepted this cycle when im_req=1.
- im_rvalid  in  1  read data valid; responses return in request order.
- im_rdata  in  32  instruction word.
- f_valid  out  1  head entry valid.
- f_pc  out  32  head PC; PC_RESET when empty.
- f_instr  out  32  head instruction; 32'h0 (nop bubble) when empty.
- f_en  out  1  F/D register enable = ~stall.

Behaviour:
- Reset (async) state: fpc=PC_RESET, queue empty, inflight=0, drop=0. Outputs: im_req=0, f_valid=0, f_pc=PC_RESET, f_instr=0.
- Counters: occ (queue entries, 0..DEPTH), inflight (granted, not yet returned, 0..DEPTH), drop (responses still to discard).
- Issue:
  - im_req = ~redirect & (occ + inflight < DEPTH), using registered values with no same-cycle pop bypass.
  - im_addr = fpc.
  - im_req & im_gnt: fpc <= fpc + 4 (wraps mod 2^32); the PC is pushed into a PC-tag FIFO; inflight++.
- Response, im_rvalid=1:
  - inflight-- in all cases.
  - If drop>0: discard the word, drop--.
  - Otherwise: pop the PC tag and push {tag, im_rdata} into the queue.
  - The credit rule guarantees the queue never overflows.
  - im_rvalid with inflight=0 is a protocol error: ignore it and leave all counters unchanged.
- Consume: pop the head when f_valid & ~stall. Outputs are combinational from the head entry, so latency from response to f_valid is 1 cycle.
- Simultaneous grant, response and pop in one cycle all take effect; net counter updates are summed.
- Redirect (highest priority):
  - In the redirect cycle: im_req=0, the queue and PC-tag FIFO are flushed, no pop occurs, and fpc <= {redirect_pc[31:2],2'b00}.
  - drop <= inflight - im_rvalid (this cycle's response is also discarded); inflight <= same value.
  - Next cycle: f_valid=0, and issue resumes at the new PC if credits allow.
  - Back-to-back redirects: the last one wins; drop accumulates correctly because it always equals the remaining inflight.
- Stall with an empty queue has no effect. Stall with a full queue: no issue until a pop frees a credit.
- Reset mid-operation: all state clears immediately. Responses arriving after reset deasserts with inflight=0 are ignored.

Test Plan:
- Reset release, im_gnt=1 and im_rvalid one cycle after each grant:
  - im_addr sequence 0x3000, 0x3004, 0x3008.
  - f_pc/f_instr follow in order with 1-cycle latency.
  - Before the first data: f_instr=0, f_pc=0x3000.
- stall held high, memory always ready:
  - At most 4 grants, then im_req=0.
  - Queue holds 0x3000..0x300C.
  - Releasing stall pops one per cycle and re-issues 0x3010.
- 2 requests in flight (0x3000, 0x3004), redirect to 0x4001:
  - Next im_addr=0x4000.
  - The two late responses are discarded.
  - First f_valid shows f_pc=0x4000.
- Redirect in the same cycle as im_rvalid and a pop:
  - The response is dropped and no pop is counted.
  - drop equals the remaining inflight; the queue is empty next cycle.
- fpc=0xFFFF_FFFC granted:
  - Next im_addr=0x0000_0000.
  - The queue entry keeps PC 0xFFFF_FFFC.
- Assert reset asynchronously mid-burst, between clock edges:
  - Outputs return to reset values immediately.
  - A stray im_rvalid after reset produces no f_valid.
